// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// EX/MEM pipeline register of the 64-bit core, with branch resolution.
//
// The stage captures the ALU result and decoded control from execute. It also
// resolves conditional branches from the ALU ZERO flag. A taken branch raises
// a one-cycle PC redirect (pc_redirect / flush_younger / branch_target). The
// instruction that follows it down the pipe is on the wrong path, so it is
// captured as a bubble. Two counters record resolved and taken branches.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   stall, flush         hold everything / kill the slot being captured
//   ex_*, alu_*          execute-stage instruction, ALU Result and ZERO
//   mem_*                registered instruction for the memory stage
//   pc_redirect          one-cycle pulse, taken branch (held under stall)
//   branch_target        ex_pc + (ex_imm << 1), valid while pc_redirect = 1
//   flush_younger        kill IF/ID and ID/EX; same as pc_redirect
//   branch_count         resolved branches (wraps)
//   taken_count          taken branches (wraps)
//
// Every output comes straight from a register. No input reaches an output
// through combinational logic.
// ---------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             stall,
  input  logic             flush,

  input  logic             ex_valid,
  input  logic [63:0]      alu_result,
  input  logic             alu_zero,
  input  logic [63:0]      ex_pc,
  input  logic [63:0]      ex_imm,
  input  logic [63:0]      ex_rs2_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,

  output logic             mem_valid,
  output logic [63:0]      mem_alu_result,
  output logic [63:0]      mem_store_data,
  output logic [4:0]       mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_mem_to_reg,

  output logic             pc_redirect,
  output logic [63:0]      branch_target,
  output logic             flush_younger,

  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  // Branch condition codes (funct3).
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // RUN: normal acceptance. REDIRECT: the slot now in EX is the wrong-path
  // successor of a taken branch and must be squashed.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        cond_met;
  logic        accept;
  logic        take;
  logic [63:0] target;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: flush beats stall, and stall freezes the state.
  // -------------------------------------------------------------------------
  // NOTE: each always_comb assigns its outputs a default first, so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else if (!stall) begin
      case (state)
        RUN:      if (take) state_nxt = REDIRECT;
        REDIRECT: state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode: acceptance and branch resolution for the current edge.
  // -------------------------------------------------------------------------
  always_comb begin
    cond_met = 1'b0;
    case (ex_funct3)
      F3_BEQ:  cond_met = alu_zero;   // Sub result zero: equal
      F3_BNE:  cond_met = !alu_zero;
      F3_BLT:  cond_met = alu_zero;   // Less yields 0 when a < b
      F3_BGE:  cond_met = !alu_zero;
      default: cond_met = 1'b0;
    endcase

    accept = ex_valid && (state == RUN) && !stall && !flush;
    take   = accept && ex_branch && cond_met;
  end

  // The immediate is in half-word units. The sum wraps silently at 2^64.
  assign target = ex_pc + (ex_imm << 1);

  // -------------------------------------------------------------------------
  // Pipeline register, redirect register and counters.
  // Priority: reset > flush > stall > normal capture.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      pc_redirect    <= 1'b0;
      branch_target  <= '0;
      branch_count   <= '0;
      taken_count    <= '0;
    end else if (flush) begin
      // Killed slot: only the controls matter, so the data fields hold.
      // The counters also hold.
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      pc_redirect    <= 1'b0;
    end else if (!stall) begin
      // On a bubble the controls are gated to 0. The data fields load
      // regardless, since nothing downstream reads them without mem_valid.
      mem_valid      <= accept;
      mem_reg_write  <= accept && ex_reg_write;
      mem_mem_read   <= accept && ex_mem_read;
      mem_mem_write  <= accept && ex_mem_write;
      mem_mem_to_reg <= accept && ex_mem_to_reg;
      mem_alu_result <= alu_result;
      mem_store_data <= ex_rs2_data;
      mem_rd         <= ex_rd;

      // The pulse lasts exactly one unstalled cycle. A stall holds it high,
      // so fetch must act on it only once.
      pc_redirect    <= take;
      if (take) begin
        branch_target <= target;
      end

      if (accept && ex_branch) begin
        branch_count <= branch_count + CNT_ONE;
      end
      if (take) begin
        taken_count <= taken_count + CNT_ONE;
      end
    end
  end

  assign flush_younger = pc_redirect;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Directed bench for ex_mem_stage. Expected values are written out by hand.
// A second instance with CNT_W = 4 shares the same stimulus and exercises
// counter wrap without millions of cycles.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic [63:0] ex_pc;
  logic [63:0] ex_imm;
  logic [63:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_branch;
  logic [2:0]  ex_funct3;

  logic        mem_valid;
  logic [63:0] mem_alu_result;
  logic [63:0] mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        mem_mem_to_reg;
  logic        pc_redirect;
  logic [63:0] branch_target;
  logic        flush_younger;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  // Outputs of the narrow-counter instance
  logic        s_mem_valid;
  logic [63:0] s_mem_alu_result;
  logic [63:0] s_mem_store_data;
  logic [4:0]  s_mem_rd;
  logic        s_mem_reg_write;
  logic        s_mem_mem_read;
  logic        s_mem_mem_write;
  logic        s_mem_mem_to_reg;
  logic        s_pc_redirect;
  logic [63:0] s_branch_target;
  logic        s_flush_younger;
  logic [3:0]  s_branch_count;
  logic [3:0]  s_taken_count;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .alu_result(alu_result), .alu_zero(alu_zero),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .pc_redirect(pc_redirect), .branch_target(branch_target),
    .flush_younger(flush_younger),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  ex_mem_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .alu_result(alu_result), .alu_zero(alu_zero),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .mem_valid(s_mem_valid), .mem_alu_result(s_mem_alu_result),
    .mem_store_data(s_mem_store_data), .mem_rd(s_mem_rd),
    .mem_reg_write(s_mem_reg_write), .mem_mem_read(s_mem_mem_read),
    .mem_mem_write(s_mem_mem_write), .mem_mem_to_reg(s_mem_mem_to_reg),
    .pc_redirect(s_pc_redirect), .branch_target(s_branch_target),
    .flush_younger(s_flush_younger),
    .branch_count(s_branch_count), .taken_count(s_taken_count)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    alu_result    = '0;
    alu_zero      = 1'b0;
    ex_pc         = '0;
    ex_imm        = '0;
    ex_rs2_data   = '0;
    ex_rd         = '0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_mem_to_reg = 1'b0;
    ex_branch     = 1'b0;
    ex_funct3     = 3'b000;
  endtask

  // Non-branch ALU instruction writing rd.
  task automatic alu_op(input logic [63:0] res, input logic [4:0] rd);
    idle();
    ex_valid     = 1'b1;
    alu_result   = res;
    ex_rd        = rd;
    ex_reg_write = 1'b1;
  endtask

  task automatic branch_op(input logic [2:0] f3, input logic zero,
                           input logic [63:0] pc, input logic [63:0] imm);
    idle();
    ex_valid   = 1'b1;
    ex_branch  = 1'b1;
    ex_funct3  = f3;
    alu_zero   = zero;
    ex_pc      = pc;
    ex_imm     = imm;
    alu_result = 64'hAA;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    tick();
    tick();

    // Reset state
    check("rst_mem_valid",     mem_valid, 0);
    check("rst_mem_alu",       mem_alu_result, 0);
    check("rst_mem_reg_write", mem_reg_write, 0);
    check("rst_pc_redirect",   pc_redirect, 0);
    check("rst_flush_younger", flush_younger, 0);
    check("rst_branch_target", branch_target, 0);
    check("rst_branch_count",  branch_count, 0);
    check("rst_taken_count",   taken_count, 0);
    reset = 1'b0;

    // Plain ALU op, one-edge latency
    alu_op(64'hFF, 5'd5);
    tick();
    check("alu_mem_valid",     mem_valid, 1);
    check("alu_mem_result",    mem_alu_result, 64'hFF);
    check("alu_mem_rd",        mem_rd, 5);
    check("alu_mem_reg_write", mem_reg_write, 1);
    check("alu_branch_count",  branch_count, 0);
    check("alu_pc_redirect",   pc_redirect, 0);

    // BEQ taken; the following instruction is squashed, then re-accepted
    branch_op(3'b000, 1'b1, 64'h1000, 64'h10);
    tick();
    check("beq_pc_redirect",   pc_redirect, 1);
    check("beq_flush_younger", flush_younger, 1);
    check("beq_target",        branch_target, 64'h1020);
    check("beq_taken_count",   taken_count, 1);
    check("beq_branch_count",  branch_count, 1);
    alu_op(64'h123, 5'd7);
    tick();
    check("sq_pc_redirect",    pc_redirect, 0);
    check("sq_mem_valid",      mem_valid, 0);
    check("sq_mem_reg_write",  mem_reg_write, 0);
    tick();
    check("post_sq_mem_valid", mem_valid, 1);
    check("post_sq_mem_rd",    mem_rd, 7);

    // Not-taken branches and an unsupported condition code
    branch_op(3'b001, 1'b1, 64'h1100, 64'h4);   // BNE, zero=1
    tick();
    check("bne_nt_redirect",   pc_redirect, 0);
    branch_op(3'b100, 1'b0, 64'h1104, 64'h4);   // BLT, zero=0
    tick();
    check("blt_nt_redirect",   pc_redirect, 0);
    branch_op(3'b010, 1'b1, 64'h1108, 64'h4);   // funct3 010: never taken
    tick();
    check("f3_010_redirect",   pc_redirect, 0);
    check("nt_branch_count",   branch_count, 4);
    check("nt_taken_count",    taken_count, 1);

    // BGE taken with a negative immediate
    branch_op(3'b101, 1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("bge_redirect",      pc_redirect, 1);
    check("bge_target",        branch_target, 64'h1FF8);
    idle();
    tick();
    check("bge_sq_redirect",   pc_redirect, 0);

    // BLT taken with a target that wraps past 2^64
    branch_op(3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10);
    tick();
    check("blt_wrap_redirect", pc_redirect, 1);
    check("blt_wrap_target",   branch_target, 64'h10);
    check("blt_taken_count",   taken_count, 3);
    check("blt_branch_count",  branch_count, 6);
    idle();
    tick();

    // Redirect held across a 3-cycle stall, then one squash, then flow
    branch_op(3'b000, 1'b1, 64'h3000, 64'h8);
    tick();
    check("stb_redirect",      pc_redirect, 1);
    check("stb_target",        branch_target, 64'h3010);
    alu_op(64'h99, 5'd9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_redirect",    pc_redirect, 1);
      check("stl_target",      branch_target, 64'h3010);
      check("stl_mem_alu",     mem_alu_result, 64'hAA);
      check("stl_taken_count", taken_count, 4);
    end
    stall = 1'b0;
    tick();
    check("stl_sq_redirect",   pc_redirect, 0);
    check("stl_sq_mem_valid",  mem_valid, 0);
    check("stl_sq_reg_write",  mem_reg_write, 0);
    tick();
    check("stl_rs_mem_valid",  mem_valid, 1);
    check("stl_rs_mem_rd",     mem_rd, 9);
    check("stl_branch_count",  branch_count, 7);

    // flush + stall while in REDIRECT
    branch_op(3'b000, 1'b1, 64'h4000, 64'h0);
    tick();
    check("fs_redirect_on",    pc_redirect, 1);
    check("fs_target",         branch_target, 64'h4000);
    alu_op(64'h10, 5'd10);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    check("fs_mem_valid",      mem_valid, 0);
    check("fs_mem_reg_write",  mem_reg_write, 0);
    check("fs_redirect",       pc_redirect, 0);
    check("fs_flush_younger",  flush_younger, 0);
    check("fs_taken_count",    taken_count, 5);
    check("fs_branch_count",   branch_count, 8);
    flush = 1'b0;
    stall = 1'b0;
    alu_op(64'h11, 5'd11);
    tick();
    check("fs_next_mem_valid", mem_valid, 1);
    check("fs_next_mem_rd",    mem_rd, 11);

    // flush in RUN kills a would-be taken branch
    branch_op(3'b000, 1'b1, 64'h4800, 64'h4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fr_redirect",       pc_redirect, 0);
    check("fr_mem_valid",      mem_valid, 0);
    check("fr_branch_count",   branch_count, 8);

    // Reset during REDIRECT cuts the pulse; no squash afterwards
    branch_op(3'b000, 1'b1, 64'h5000, 64'h1);
    tick();
    check("rr_redirect_on",    pc_redirect, 1);
    check("rr_target",         branch_target, 64'h5002);
    alu_op(64'h12, 5'd12);
    reset = 1'b1;
    tick();
    check("rr_redirect",       pc_redirect, 0);
    check("rr_mem_valid",      mem_valid, 0);
    check("rr_taken_count",    taken_count, 0);
    check("rr_branch_target",  branch_target, 0);
    reset = 1'b0;
    tick();
    check("rr_next_mem_valid", mem_valid, 1);
    check("rr_next_mem_rd",    mem_rd, 12);

    // Counter wrap on the 4-bit instance: 15 reaches 0xF, 16 wraps to 0
    for (int i = 1; i <= 16; i++) begin
      branch_op(3'b000, 1'b1, 64'h6000, 64'h2);
      tick();
      idle();
      tick();
      if (i == 15) begin
        check("wrap_small_at_max", s_taken_count, 4'hF);
      end
    end
    check("wrap_small_taken",  s_taken_count, 0);
    check("wrap_small_branch", s_branch_count, 0);
    check("wrap_big_taken",    taken_count, 16);
    check("wrap_big_branch",   branch_count, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
